// File: rtl/skid_buffer_x71_if.sv
// Valid/ready handshake bundle for the two-entry skid buffer.
// master = upstream/downstream driver side, slave = the buffer itself.
interface skid_buffer_x71_if #(
  parameter int LENGTH = 71
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [LENGTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [LENGTH-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  occupancy
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output occupancy
  );
endinterface

// File: rtl/skid_buffer_x71.sv
// Two-entry valid/ready skid buffer for 71-bit micro-op payloads.
// Head register drives out_data, skid register holds the second entry.
// All outputs are register or state decode only, so no combinational
// path exists from the input side to the output side or back.
module skid_buffer_x71 #(
  parameter int LENGTH = 71
) (
  input  logic              clk,
  input  logic              reset,
  skid_buffer_x71_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] head_q, head_d;
  logic [LENGTH-1:0] skid_q, skid_d;

  logic push;
  logic pop;

  // Output decode straight from the state register.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = head_q;

  // Occupancy mirrors the legal encodings; the unreachable code reads as 0.
  always_comb begin
    bus.occupancy = 2'd0;
    case (state_q)
      ONE:     bus.occupancy = 2'd1;
      FULL:    bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Next-state and data-register load selection.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      // Squash: drop everything, including a push arriving this cycle.
      // Data registers keep stale contents; out_valid hides them.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = bus.in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d  = bus.in_data;
          end else if (push) begin
            skid_d  = bus.in_data;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          // Illegal encoding recovers to empty.
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_buffer_x71.sv
// Self-checking bench for skid_buffer_x71: reset checks, a directed vector
// table, streaming, async reset mid-transfer and a randomized run against a
// queue-based reference model.
module tb_skid_buffer_x71;

  localparam int LENGTH = 71;

  logic clk;
  logic reset;

  int checks;
  int errors;

  skid_buffer_x71_if #(.LENGTH(LENGTH)) sb ();

  skid_buffer_x71 #(.LENGTH(LENGTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              flush;
    logic              in_valid;
    logic [LENGTH-1:0] in_data;
    logic              out_ready;
    logic              exp_valid;
    logic              exp_ready;
    logic [1:0]        exp_occ;
    logic              chk_data;
    logic [LENGTH-1:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [LENGTH-1:0] act,
                     input logic [LENGTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic r,
                          input logic [1:0] occ);
    chk({tag, ".out_valid"}, LENGTH'(sb.out_valid), LENGTH'(v));
    chk({tag, ".in_ready"},  LENGTH'(sb.in_ready),  LENGTH'(r));
    chk({tag, ".occupancy"}, LENGTH'(sb.occupancy), LENGTH'(occ));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic f, input logic iv,
                        input logic [LENGTH-1:0] d, input logic ordy);
    sb.flush     = f;
    sb.in_valid  = iv;
    sb.in_data   = d;
    sb.out_ready = ordy;
  endtask

  function automatic vec_t mk(input logic f, input logic iv,
                              input logic [LENGTH-1:0] d, input logic ordy,
                              input logic ev, input logic er,
                              input logic [1:0] eo, input logic cd,
                              input logic [LENGTH-1:0] ed);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
    v.exp_valid = ev; v.exp_ready = er; v.exp_occ = eo;
    v.chk_data = cd; v.exp_data = ed;
    return v;
  endfunction

  logic [LENGTH-1:0] model_q[$];
  logic [LENGTH-1:0] rnd;
  logic              m_push;
  logic              m_pop;

  initial begin
    checks = 0;
    errors = 0;

    // Each vector: inputs held for one cycle, expectations after that edge.
    //            flush iv  data        ordy  v  r  occ  cd  data
    vecs[0]  = mk(0, 1, 71'h0ABC, 1,    1, 1, 2'd1, 1, 71'h0ABC);
    vecs[1]  = mk(0, 0, 71'h0,    1,    0, 1, 2'd0, 0, 71'h0);
    vecs[2]  = mk(0, 1, 71'h1,    0,    1, 1, 2'd1, 1, 71'h1);
    vecs[3]  = mk(0, 1, 71'h2,    0,    1, 0, 2'd2, 1, 71'h1);
    vecs[4]  = mk(0, 1, 71'h3,    0,    1, 0, 2'd2, 1, 71'h1);
    vecs[5]  = mk(0, 1, 71'h3,    1,    1, 1, 2'd1, 1, 71'h2);
    vecs[6]  = mk(0, 1, 71'h3,    1,    1, 1, 2'd1, 1, 71'h3);
    vecs[7]  = mk(0, 0, 71'h0,    1,    0, 1, 2'd0, 0, 71'h0);
    vecs[8]  = mk(0, 1, 71'hAA,   0,    1, 1, 2'd1, 1, 71'hAA);
    vecs[9]  = mk(0, 1, 71'hBB,   0,    1, 0, 2'd2, 1, 71'hAA);
    vecs[10] = mk(1, 1, 71'h7F,   1,    0, 1, 2'd0, 0, 71'h0);
    vecs[11] = mk(0, 0, 71'h0,    0,    0, 1, 2'd0, 0, 71'h0);
    vecs[12] = mk(1, 1, 71'h55,   0,    0, 1, 2'd0, 0, 71'h0);
    vecs[13] = mk(0, 1, 71'h66,   0,    1, 1, 2'd1, 1, 71'h66);
    vecs[14] = mk(1, 0, 71'h0,    0,    0, 1, 2'd0, 0, 71'h0);
    vecs[15] = mk(0, 0, 71'h0,    1,    0, 1, 2'd0, 0, 71'h0);

    // Reset with a payload offered: nothing captured, outputs cleared.
    reset = 1'b1;
    set_in(0, 1, 71'h1F, 1);
    #1;
    chk_outs("reset_async", 0, 1, 2'd0);
    chk("reset_async.out_data", sb.out_data, 71'h0);
    repeat (3) step();
    chk_outs("reset_held", 0, 1, 2'd0);
    chk("reset_held.out_data", sb.out_data, 71'h0);
    $display("reset: out_valid=%0b in_ready=%0b occ=%0d", sb.out_valid, sb.in_ready, sb.occupancy);
    set_in(0, 0, 71'h0, 0);
    reset = 1'b0;
    step();
    chk_outs("post_reset", 0, 1, 2'd0);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ready, vecs[i].exp_occ);
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d.out_data", i), sb.out_data, vecs[i].exp_data);
      if (sb.out_valid && sb.out_data == 71'h7F)
        chk($sformatf("vec%0d.squashed_7F_seen", i), 71'h1, 71'h0);
      $display("vec%0d: flush=%0b iv=%0b din=%0h ordy=%0b -> v=%0b r=%0b occ=%0d dout=%0h",
               i, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready,
               sb.out_valid, sb.in_ready, sb.occupancy, sb.out_data);
    end

    // Streaming: one payload in, one out, every cycle.
    for (int i = 0; i < 100; i++) begin
      set_in(0, 1, LENGTH'(1000 + i), 1);
      step();
      chk($sformatf("stream%0d.out_valid", i), LENGTH'(sb.out_valid), LENGTH'(1));
      chk($sformatf("stream%0d.out_data", i), sb.out_data, LENGTH'(1000 + i));
      chk($sformatf("stream%0d.occ", i), LENGTH'(sb.occupancy), LENGTH'(1));
    end
    $display("stream: 100 payloads issued");
    set_in(0, 0, 71'h0, 1);
    step();
    chk_outs("stream_end", 0, 1, 2'd0);

    // Asynchronous reset while FULL, asserted between clock edges.
    set_in(0, 1, 71'h11, 0);
    step();
    set_in(0, 1, 71'h22, 0);
    step();
    chk_outs("pre_async_reset", 1, 0, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_outs("async_reset_mid", 0, 1, 2'd0);
    chk("async_reset_mid.out_data", sb.out_data, 71'h0);
    $display("async reset mid-transfer: occ=%0d dout=%0h", sb.occupancy, sb.out_data);
    step();
    set_in(0, 0, 71'h0, 0);
    reset = 1'b0;
    step();
    chk_outs("after_async_reset", 0, 1, 2'd0);
    set_in(0, 1, 71'h33, 0);
    step();
    chk("after_async_reset.first", sb.out_data, 71'h33);
    set_in(0, 0, 71'h0, 1);
    step();
    chk_outs("after_async_reset.drained", 0, 1, 2'd0);

    // Randomized run against a capacity-2 FIFO model.
    model_q.delete();
    for (int c = 0; c < 3000; c++) begin
      rnd[31:0]  = $urandom;
      rnd[63:32] = $urandom;
      rnd[70:64] = 7'($urandom);
      set_in(($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0), rnd,
             ($urandom_range(2, 0) != 0));
      chk_outs($sformatf("rnd%0d", c), (model_q.size() != 0), (model_q.size() < 2),
               2'(model_q.size()));
      if (model_q.size() != 0)
        chk($sformatf("rnd%0d.out_data", c), sb.out_data, model_q[0]);
      m_push = sb.in_valid && (model_q.size() < 2);
      m_pop  = sb.out_ready && (model_q.size() != 0);
      step();
      if (sb.flush) begin
        model_q.delete();
      end else begin
        if (m_pop)  void'(model_q.pop_front());
        if (m_push) model_q.push_back(sb.in_data);
      end
      if (c % 500 == 0)
        $display("rnd%0d: flush=%0b push=%0b pop=%0b model_occ=%0d", c, sb.flush, m_push, m_pop, model_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
